// File: rtl/dense_pkg.sv
// dense_pkg
// Shared types for the dense-layer result serializer.
//   ENGINE_IDX_W : width of an engine lane index (12 bits, up to 4095 lanes)
//   engine_idx_t : engine lane index type
//   ser_state_e  : serializer FSM states (IDLE, STREAM, DONE)
package dense_pkg;

    localparam int ENGINE_IDX_W = 12;

    typedef logic [ENGINE_IDX_W-1:0] engine_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } ser_state_e;

endpackage

// File: rtl/dense_snapshot_bank.sv
// dense_snapshot_bank
// Register bank holding one copy of every dense lane, so the dense layer can
// start its next accumulation while the previous results drain.
// Ports:
//   clk_i       : clock, rising edge
//   load_i      : copy all lanes of wr_data_i into the bank this edge
//   wr_data_i   : EngineCount x N lane values to capture
//   rd_idx_i    : lane to read
//   rd_data_o   : combinational read of lane rd_idx_i (0 if out of range)
module dense_snapshot_bank
    import dense_pkg::*;
#(
    parameter int N           = 16,
    parameter int EngineCount = 4095
) (
    input  logic                             clk_i,
    input  logic                             load_i,
    input  logic [EngineCount-1:0][N-1:0]    wr_data_i,
    input  engine_idx_t                      rd_idx_i,
    output logic [N-1:0]                     rd_data_o
);

    logic [EngineCount-1:0][N-1:0] bank_q;
    logic [EngineCount-1:0][N-1:0] bank_d;

    // Contents are only meaningful after a load, so the bank needs no reset.
    always_comb begin
        bank_d = bank_q;
        if (load_i) begin
            bank_d = wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        bank_q <= bank_d;
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < EngineCount; i++) begin
            if (rd_idx_i == engine_idx_t'(i)) begin
                rd_data_o = bank_q[i];
            end
        end
    end

endmodule

// File: rtl/dense_result_serializer.sv
// dense_result_serializer
// Drains the per-engine dense results onto one N-bit valid/ready stream, one
// lane per beat in ascending index order, then pulses done_o for one cycle.
//
// Handshake: a beat transfers on a rising edge where valid_o and ready_i are
// both 1; while valid_o=1 and ready_i=0, data_o/index_o/last_o hold unchanged
// and valid_o stays high until the beat is taken.
//
// Optional feature macro: DENSE_SERIALIZER_SNAPSHOT_EN. When defined, all lanes
// are captured into dense_snapshot_bank on the accepted start so dense_i may
// change while draining. When undefined, dense_i must stay stable from start
// until done_o. Cycle timing is the same in both builds.
//
// Ports:
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   start_i        : start a drain (sampled only in IDLE)
//   count_i        : lanes to drain, clamped to EngineCount
//   dense_i        : EngineCount x N signed lane results
//   data_o,index_o : current beat value and its lane index
//   valid_o,ready_i,last_o : output stream handshake and final-beat marker
//   busy_o, done_o : drain in progress, one-cycle completion pulse
//   dbg_state_o    : current FSM state
module dense_result_serializer
    import dense_pkg::*;
#(
    parameter int N           = 16,
    parameter int EngineCount = 4095
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                start_i,
    input  logic [ENGINE_IDX_W-1:0]             count_i,
    input  logic signed [EngineCount-1:0][N-1:0] dense_i,
    output logic signed [N-1:0]                 data_o,
    output logic [ENGINE_IDX_W-1:0]             index_o,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic                                last_o,
    output logic                                busy_o,
    output logic                                done_o,
    output ser_state_e                          dbg_state_o
);

    ser_state_e  state_q, state_d;
    engine_idx_t idx_q, idx_d;
    engine_idx_t count_q, count_d;
    logic [N-1:0] data_q, data_d;
    logic        last_q, last_d;

    engine_idx_t count_clamped;
    engine_idx_t next_idx;
    logic [N-1:0] lane_rd;     // lane at next_idx, from bank or live input

    assign count_clamped = (count_i > engine_idx_t'(EngineCount))
                         ? engine_idx_t'(EngineCount) : count_i;
    assign next_idx      = idx_q + engine_idx_t'(1);

`ifdef DENSE_SERIALIZER_SNAPSHOT_EN
    logic bank_load;
    assign bank_load = (state_q == IDLE) && start_i;

    dense_snapshot_bank #(
        .N           (N),
        .EngineCount (EngineCount)
    ) u_bank (
        .clk_i     (clk_i),
        .load_i    (bank_load),
        .wr_data_i (dense_i),
        .rd_idx_i  (next_idx),
        .rd_data_o (lane_rd)
    );
`else
    always_comb begin
        lane_rd = '0;
        for (int i = 0; i < EngineCount; i++) begin
            if (next_idx == engine_idx_t'(i)) begin
                lane_rd = dense_i[i];
            end
        end
    end
`endif

    // Beat registers are loaded one edge ahead: the first beat comes straight
    // from dense_i[0] at the start edge (the bank is being loaded on that same
    // edge), later beats from lane next_idx as the current one is accepted.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        data_d  = '0;
        last_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    count_d = count_clamped;
                    idx_d   = '0;
                    if (count_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = STREAM;
                        data_d  = dense_i[0];
                        last_d  = (count_clamped == engine_idx_t'(1));
                    end
                end
            end
            STREAM: begin
                data_d = data_q;
                last_d = last_q;
                if (ready_i) begin
                    if (last_q) begin
                        state_d = DONE;
                        idx_d   = '0;
                        data_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = next_idx;
                        data_d = lane_rd;
                        last_d = (next_idx == count_q - engine_idx_t'(1));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // All outputs decode directly from flops; idx_q is cleared on leaving
    // STREAM so index_o reads 0 elsewhere.
    assign data_o      = data_q;
    assign index_o     = idx_q;
    assign valid_o     = (state_q == STREAM);
    assign last_o      = last_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dense_result_serializer.sv
module tb_dense_result_serializer;

  localparam int N    = 16;
  localparam int ENG  = 8;
  localparam int LIMIT = 200;

  logic                    clk_i;
  logic                    rst_n_i;
  logic                    start_i;
  logic [11:0]             count_i;
  logic [ENG-1:0][N-1:0]   dense_i;
  logic [N-1:0]            data_o;
  logic [11:0]             index_o;
  logic                    valid_o;
  logic                    ready_i;
  logic                    last_o;
  logic                    busy_o;
  logic                    done_o;
  logic [1:0]              dbg_state;

  int n_checks;
  int n_fail;
  logic [N-1:0] exp_q[$];

  dense_result_serializer #(
    .N           (N),
    .EngineCount (ENG)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .count_i     (count_i),
    .dense_i     (dense_i),
    .data_o      (data_o),
    .index_o     (index_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .last_o      (last_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_lanes(input int base);
    for (int i = 0; i < ENG; i++) dense_i[i] = N'(base + i);
  endtask

  task automatic load_exp(input int base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(N'(base + i));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_data"},  {16'd0, data_o},  32'd0);
    check({tag, "_index"}, {20'd0, index_o}, 32'd0);
    check({tag, "_last"},  {31'd0, last_o},  32'd0);
  endtask

  // mode 0: ready always 1; mode 1: ready pattern 1,0,0 repeating.
  // poke: pulse start_i mid-stream (must be ignored).
  // clobber: zero dense_i one cycle after start (snapshot build only).
  task automatic drain(input int n_req, input int n_exp, input int mode,
                       input bit poke, input bit clobber);
    int got;
    int cyc;
    bit prev_stall;
    logic [N-1:0] prev_data;
    logic [11:0]  prev_idx;
    logic [N-1:0] exp_v;
    start_i = 1'b1;
    count_i = 12'(n_req);
    tick();
    start_i = 1'b0;
    if (n_exp > 0) begin
      check("first_valid", {31'd0, valid_o}, 32'd1);
      check("first_index", {20'd0, index_o}, 32'd0);
      check("first_busy",  {31'd0, busy_o},  32'd1);
    end
    got = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_idx = '0;
    while (got < n_exp && cyc < LIMIT) begin
`ifdef DENSE_SERIALIZER_SNAPSHOT_EN
      if (clobber && cyc == 0) dense_i = '0;
`else
      if (clobber && cyc == 0) dense_i = dense_i;
`endif
      if (poke && cyc == 2) begin
        start_i = 1'b1;
        count_i = 12'd2;
      end else begin
        start_i = 1'b0;
      end
      ready_i = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      check("stream_valid", {31'd0, valid_o}, 32'd1);
      if (prev_stall) begin
        check("hold_data",  {16'd0, data_o},  {16'd0, prev_data});
        check("hold_index", {20'd0, index_o}, {20'd0, prev_idx});
      end
      if (ready_i) begin
        exp_v = exp_q.pop_front();
        check("beat_data",  {16'd0, data_o},  {16'd0, exp_v});
        check("beat_index", {20'd0, index_o}, 32'(got));
        check("beat_last",  {31'd0, last_o},  {31'd0, (got == n_exp - 1)});
        got++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_data = data_o;
        prev_idx = index_o;
      end
      tick();
      cyc++;
    end
    start_i = 1'b0;
    if (cyc >= LIMIT) check("drain_timeout", 32'(got), 32'(n_exp));
    if (mode == 0) check("throughput_cycles", 32'(cyc), 32'(n_exp));
    check("done_pulse", {31'd0, done_o}, 32'd1);
    check("done_busy",  {31'd0, busy_o}, 32'd1);
    check_idle_outputs("done");
    tick();
    check("done_drop", {31'd0, done_o}, 32'd0);
    check("idle_busy", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n_i = 1'b0;
    start_i = 1'b0;
    count_i = '0;
    ready_i = 1'b0;
    dense_i = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    check("reset_busy",  {31'd0, busy_o}, 32'd0);
    check("reset_done",  {31'd0, done_o}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    rst_n_i = 1'b1;
    tick();

    // full throughput, lanes 100..107
    set_lanes(100);
    load_exp(100, 8);
    drain(8, 8, 0, 1'b0, 1'b0);

    // backpressure 1,0,0 pattern
    load_exp(100, 8);
    drain(8, 8, 1, 1'b0, 1'b0);

    // zero count: done in T+1, no beats
    exp_q.delete();
    drain(0, 0, 0, 1'b0, 1'b0);

    // count 20 clamps to 8, start during STREAM ignored
    set_lanes(200);
    load_exp(200, 8);
    drain(20, 8, 0, 1'b1, 1'b0);

    // signed extremes bit-exact
    dense_i[0] = 16'hFFFF;
    dense_i[1] = 16'h8000;
    dense_i[2] = 16'h7FFF;
    dense_i[3] = 16'h0001;
    exp_q.delete();
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h8000);
    exp_q.push_back(16'h7FFF);
    exp_q.push_back(16'h0001);
    drain(4, 4, 1, 1'b0, 1'b0);

    // reset after the third beat aborts with no done pulse
    set_lanes(100);
    ready_i = 1'b1;
    start_i = 1'b1;
    count_i = 12'd8;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    check("pre_reset_index", {20'd0, index_o}, 32'd3);
    check("pre_reset_data",  {16'd0, data_o},  32'd103);
    rst_n_i = 1'b0;
    tick();
    check_idle_outputs("abort");
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_done", {31'd0, done_o}, 32'd0);
    rst_n_i = 1'b1;
    tick();
    check("post_abort_done", {31'd0, done_o}, 32'd0);
    check("post_abort_valid", {31'd0, valid_o}, 32'd0);

    // restart from index 0; snapshot build zeros dense_i mid-drain
    load_exp(100, 8);
    drain(8, 8, 0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_result_serializer.md
# dense_result_serializer

Drains the parallel per-engine results of the dense layer into a single N-bit valid/ready stream, one engine value per beat, in ascending engine index order. Sits between the dense layer's `dense_o` vector and the downstream result buffer / host readback path. A start pulse launches one drain of `count_i` values; a one-cycle done pulse marks completion.

## Interface
Parameters:
- `N`, 16, bit width of each dense result and of the output beat
- `EngineCount`, 4095, number of engine lanes on `dense_i` (maximum 4095, 12-bit index)

Ports:
- `clk_i` input 1: single clock; all logic on the rising edge
- `rst_n_i` input 1: reset, synchronous, active-low
- `start_i` input 1: start a drain; sampled only in IDLE
- `count_i` input 12: number of lanes to drain, sampled with `start_i`
- `dense_i` input `[EngineCount-1:0]` x N signed: per-engine results
- `data_o` output N signed: current beat value
- `index_o` output 12: engine index of the current beat
- `valid_o` output 1: beat valid
- `ready_i` input 1: downstream accepts beat
- `last_o` output 1: current beat is the final one
- `busy_o` output 1: drain in progress
- `done_o` output 1: one-cycle completion pulse

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE: `start_i`=1 latches `count_q` = min(`count_i`, EngineCount), clears `idx_q`. If `count_q` would be 0 -> DONE, else -> STREAM.
- STREAM: `valid_o`=1, `data_o`=lane `idx_q`, `index_o`=`idx_q`, `last_o`=(`idx_q`==`count_q`-1). On `valid_o & ready_i`: if last -> DONE, else `idx_q`+1. Without `ready_i`, `data_o`/`index_o`/`last_o` hold.
- DONE: `done_o`=1 for exactly one cycle, then IDLE unconditionally.
- `start_i` in STREAM or DONE is ignored (no queueing).
- `busy_o`=1 in STREAM and DONE.
- `data_o` is a bit-exact copy of the lane; no shift, saturation or sign change.
- `valid_o`, `last_o`, `data_o`, `index_o` are 0 outside STREAM.
- Reset: all outputs 0, FSM IDLE, `idx_q`/`count_q` 0. Reset mid-drain aborts with no done pulse; the beat in flight is dropped.

## Timing
- `start_i` at edge T -> first beat (`valid_o`=1, index 0) visible after T, i.e. in cycle T+1.
- Full throughput with `ready_i` held high: one beat per cycle, `count` cycles in STREAM.
- Last beat accepted in cycle K -> `done_o`=1 in cycle K+1, `busy_o`=0 and new start accepted from cycle K+2.
- count=0: `done_o` in cycle T+1, no beats.
- All outputs registered; no combinational path from `ready_i` or `dense_i` to any output.

## Configuration
- `DENSE_SERIALIZER_SNAPSHOT_EN` defined: on accepted start, all EngineCount lanes of `dense_i` are copied into an internal bank; beats come from the bank, so `dense_i` may change (next accumulation) while draining.
- Not defined: no bank; beats are read from the `dense_i` lane at `idx_q`, registered. `dense_i` must be held stable from start until `done_o`. Cycle timing is identical in both builds.

## Structure
- Shared package `dense_pkg`: `engine_idx_t` (12-bit index type), `ser_state_e` enum (IDLE, STREAM, DONE), `ENGINE_IDX_W` = 12.
- One sub-module: `dense_snapshot_bank` (EngineCount x N register bank, load enable, indexed read), instantiated only under `DENSE_SERIALIZER_SNAPSHOT_EN`.

## Test plan
- N=16, EngineCount=8, lanes = 100..107, count=8, ready always 1 -> eight beats 100..107 on consecutive cycles, indices 0..7, `last_o` on index 7, `done_o` one cycle later.
- Same, `ready_i` toggling 1,0,0,1,... -> each value held stable while `ready_i`=0, no beat skipped or duplicated, order 100..107.
- count=0 -> no `valid_o`, `done_o`=1 in cycle T+1; count=20 with EngineCount=8 -> clamped to 8 beats.
- Signed lanes -1 (16'hFFFF) and -32768 (16'h8000) -> emitted bit-exact.
- `rst_n_i`=0 after third beat -> next cycle all outputs 0, no `done_o`; subsequent start drains from index 0; `start_i` during STREAM ignored.
- Snapshot build: change `dense_i` to all 0 one cycle after start -> stream still 100..107; non-snapshot build with held inputs -> identical output.
